clock_timekeeper: RTL and testbench
===================================

CLOCK_TIMEKEEPER -- requirements
Module: clock_timekeeper

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, meaning i_clk frequency in Hz; must be >= 2.
REQ-002 i_clk  input  1  system clock; all state changes on the rising edge.
REQ-003 i_reset  input  1  asynchronous, active-low reset.
REQ-004 i_ena  input  1  global enable; low freezes all state and forces pulse outputs low.
REQ-005 i_set_mode  input  1  level; high selects time-set mode and stops timekeeping.
REQ-006 i_inc_hh  input  1  single-cycle, pre-debounced pulse; advances hours by one.
REQ-007 i_inc_mm  input  1  single-cycle, pre-debounced pulse; advances minutes by one.
REQ-008 i_clr_ss  input  1  single-cycle, pre-debounced pulse; zeroes seconds and the prescaler.
REQ-009 o_hh  output  8  hours as packed BCD {tens,units}, range 01..12.
REQ-010 o_mm  output  8  minutes as packed BCD, range 00..59.
REQ-011 o_ss  output  8  seconds as packed BCD, range 00..59.
REQ-012 o_pm  output  1  high for PM, low for AM.
REQ-013 o_clock_pulse  output  1  one-cycle pulse on each one-second advance.
REQ-014 o_input_pulse  output  1  one-cycle pulse on each accepted set edit.
REQ-015 o_wr  output  1  registered copy of i_set_mode (edit in progress).

Function
REQ-016 Prescaler shall count 0..CLK_HZ-1 while i_ena=1 and o_wr=0; terminal count shall wrap it to 0 and generate a tick.
REQ-017 On a tick, seconds shall advance by one; o_ss shall show the new value, and o_clock_pulse shall be high, in the same cycle (one cycle after terminal count).
REQ-018 Seconds 59->00 shall carry into minutes, and minutes 59->00 shall carry into hours, within the same update cycle.
REQ-019 Hours sequence shall be 12,01,02..11,12; transition 11->12 shall toggle o_pm; 12->01 shall not toggle o_pm.
REQ-020 BCD units digit shall roll 9->0 with tens+1; no output digit shall ever hold a value above 9 or outside its range.
REQ-021 When o_wr=1, prescaler shall be held at 0, no ticks shall occur, and o_clock_pulse shall be 0.
REQ-022 i_inc_hh, i_inc_mm and i_clr_ss shall be accepted only when o_wr=1 and i_ena=1; otherwise they shall be ignored.
REQ-023 Accepted i_inc_hh shall follow the REQ-019 hours sequence, including the o_pm toggle on 11->12.
REQ-024 Accepted i_inc_mm shall wrap 59->00 with no carry into hours.
REQ-025 Accepted i_clr_ss shall set o_ss=00 and the prescaler to 0.
REQ-026 Each accepted edit shall assert o_input_pulse for exactly one cycle, in the cycle in which the updated value appears.
REQ-027 Simultaneous accepted edits in one cycle shall all apply, with one o_input_pulse.
REQ-028 On an o_wr 1->0 transition, counting shall resume from prescaler 0, so the first tick follows CLK_HZ enabled cycles later.
REQ-029 With i_ena=0, all registers shall hold and o_clock_pulse/o_input_pulse shall be 0; resume shall continue from the held prescaler value.

Reset
REQ-030 While i_reset=0: o_hh=8'h12, o_mm=8'h00, o_ss=8'h00, o_pm=0, o_clock_pulse=0, o_input_pulse=0, o_wr=0, prescaler=0.
REQ-031 Reset asserted mid-count or mid-edit shall abandon the operation immediately, with no partial carry retained.
REQ-032 First tick after reset release shall occur after CLK_HZ enabled cycles.

Structure
REQ-033 A shared package shall hold the BCD constants (SS_MAX=8'h59, MM_MAX=8'h59, HH_MIN=8'h01, HH_MAX=8'h12, HH_PM_EDGE=8'h11) and the packed-BCD digit width.
REQ-034 A sub-module bcd2_counter (two-digit BCD counter: inc, load value, min/max wrap parameters, carry out) shall be instantiated for ss, mm and hh.
REQ-035 Prescaler width shall be $clog2(CLK_HZ); all outputs shall be registered.

Verification (CLK_HZ=4)
REQ-036 Reset release, i_ena=1 -> 12:00:00 AM held; o_clock_pulse first high 4 cycles later with o_ss=01.
REQ-037 Preload 11:59:59 AM via edits, leave set mode, run one tick -> 12:00:00, o_pm=1, single o_clock_pulse.
REQ-038 At 12:59:59 PM, tick -> 01:00:00 with o_pm still 1; at 09:59:59, tick -> 10:00:00 with no invalid BCD.
REQ-039 Set mode with mm=59, pulse i_inc_mm -> mm=00, hh unchanged, one o_input_pulse, no o_clock_pulse for 20 cycles.
REQ-040 i_inc_hh with i_set_mode=0 -> ignored, o_input_pulse=0; i_ena=0 for 10 cycles -> all outputs frozen, then counting resumes from the held prescaler.
REQ-041 Drop i_reset mid-prescaler at 05:30:17 PM -> outputs reset asynchronously to 12:00:00 AM; o_wr=0.

Source files
------------

// File: rtl/clock_timekeeper_pkg.sv
// Shared BCD constants and helpers for the 12-hour timekeeper.
package clock_timekeeper_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD2_W  = 2 * DIGIT_W;

  localparam logic [BCD2_W-1:0] SS_MAX     = 8'h59;
  localparam logic [BCD2_W-1:0] MM_MAX     = 8'h59;
  localparam logic [BCD2_W-1:0] HH_MIN     = 8'h01;
  localparam logic [BCD2_W-1:0] HH_MAX     = 8'h12;
  localparam logic [BCD2_W-1:0] HH_PM_EDGE = 8'h11;
  localparam logic [BCD2_W-1:0] BCD_ZERO   = 8'h00;

  // Increment a packed two-digit BCD value; units 9 rolls to 0 with tens+1.
  function automatic logic [BCD2_W-1:0] bcd2_inc(input logic [BCD2_W-1:0] v);
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
    tens  = v[BCD2_W-1:DIGIT_W];
    units = v[DIGIT_W-1:0];
    if (units >= DIGIT_W'(9)) begin
      units = '0;
      tens  = tens + DIGIT_W'(1);
    end else begin
      units = units + DIGIT_W'(1);
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/clock_timekeeper_bcd2_counter.sv
// Two-digit BCD counter with MIN..MAX wrap, load, and a carry flag raised
// when an increment occurs while the value equals CARRY_AT.
module bcd2_counter
  import clock_timekeeper_pkg::*;
#(
  parameter logic [BCD2_W-1:0] MIN_VAL  = 8'h00,
  parameter logic [BCD2_W-1:0] MAX_VAL  = 8'h59,
  parameter logic [BCD2_W-1:0] RST_VAL  = 8'h00,
  parameter logic [BCD2_W-1:0] CARRY_AT = MAX_VAL
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_inc,
  input  logic              i_load,
  input  logic [BCD2_W-1:0] i_load_val,
  output logic [BCD2_W-1:0] o_value,
  output logic              o_carry_c
);

  logic [BCD2_W-1:0] r_value;

  assign o_value   = r_value;
  assign o_carry_c = i_inc && (r_value == CARRY_AT);

  // Value register: load has priority, increment wraps MAX back to MIN.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_value <= RST_VAL;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_inc) begin
      r_value <= (r_value == MAX_VAL) ? MIN_VAL : bcd2_inc(r_value);
    end
  end

endmodule

// File: rtl/clock_timekeeper.sv
// 12-hour BCD clock: one-second prescaler, hh:mm:ss chain, AM/PM, set mode.
module clock_timekeeper
  import clock_timekeeper_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ena,
  input  logic              i_set_mode,
  input  logic              i_inc_hh,
  input  logic              i_inc_mm,
  input  logic              i_clr_ss,
  output logic [BCD2_W-1:0] o_hh,
  output logic [BCD2_W-1:0] o_mm,
  output logic [BCD2_W-1:0] o_ss,
  output logic              o_pm,
  output logic              o_clock_pulse,
  output logic              o_input_pulse,
  output logic              o_wr
);

  localparam int unsigned     PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] r_presc;
  logic             r_wr;
  logic             r_pm;
  logic             r_clock_pulse;
  logic             r_input_pulse;

  logic w_run;
  logic w_tick;
  logic w_edit;
  logic w_inc_hh;
  logic w_inc_mm;
  logic w_clr_ss;
  logic w_edit_any;
  logic w_ss_carry;
  logic w_mm_carry;
  logic w_hh_inc;
  logic w_mm_inc;
  logic w_pm_toggle;

  // Timekeeping runs only outside set mode; edits are accepted only inside it.
  assign w_run      = i_ena && !r_wr;
  assign w_tick     = w_run && (r_presc == PRE_LAST);
  assign w_edit     = i_ena && r_wr;
  assign w_inc_hh   = w_edit && i_inc_hh;
  assign w_inc_mm   = w_edit && i_inc_mm;
  assign w_clr_ss   = w_edit && i_clr_ss;
  assign w_edit_any = w_inc_hh || w_inc_mm || w_clr_ss;
  assign w_mm_inc   = w_ss_carry || w_inc_mm;
  // Minute wraps from an edit never reach hours, only tick-driven wraps do.
  assign w_hh_inc   = w_inc_hh || (w_mm_carry && w_run);

  bcd2_counter #(
    .MIN_VAL (BCD_ZERO),
    .MAX_VAL (SS_MAX),
    .RST_VAL (BCD_ZERO),
    .CARRY_AT(SS_MAX)
  ) u_ss (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_inc     (w_tick),
    .i_load    (w_clr_ss),
    .i_load_val(BCD_ZERO),
    .o_value   (o_ss),
    .o_carry_c (w_ss_carry)
  );

  bcd2_counter #(
    .MIN_VAL (BCD_ZERO),
    .MAX_VAL (MM_MAX),
    .RST_VAL (BCD_ZERO),
    .CARRY_AT(MM_MAX)
  ) u_mm (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_inc     (w_mm_inc),
    .i_load    (1'b0),
    .i_load_val(BCD_ZERO),
    .o_value   (o_mm),
    .o_carry_c (w_mm_carry)
  );

  // Hours carry flags the 11->12 step, which is where AM/PM flips.
  bcd2_counter #(
    .MIN_VAL (HH_MIN),
    .MAX_VAL (HH_MAX),
    .RST_VAL (HH_MAX),
    .CARRY_AT(HH_PM_EDGE)
  ) u_hh (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_inc     (w_hh_inc),
    .i_load    (1'b0),
    .i_load_val(BCD_ZERO),
    .o_value   (o_hh),
    .o_carry_c (w_pm_toggle)
  );

  // Prescaler, mode copy, AM/PM flag and event pulses; everything freezes when disabled.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_presc       <= '0;
      r_wr          <= 1'b0;
      r_pm          <= 1'b0;
      r_clock_pulse <= 1'b0;
      r_input_pulse <= 1'b0;
    end else begin
      r_clock_pulse <= w_tick;
      r_input_pulse <= w_edit_any;
      if (i_ena) begin
        r_wr <= i_set_mode;
        if (r_wr || w_tick) begin
          r_presc <= '0;
        end else begin
          r_presc <= r_presc + PRE_W'(1);
        end
        if (w_pm_toggle) begin
          r_pm <= ~r_pm;
        end
      end
    end
  end

  assign o_pm          = r_pm;
  assign o_clock_pulse = r_clock_pulse;
  assign o_input_pulse = r_input_pulse;
  assign o_wr          = r_wr;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Bench for clock_timekeeper with CLK_HZ=4: vector table, directed corner
// sequences and randomized stimulus against a seconds-of-day reference model.
module tb_clock_timekeeper;

  localparam int CLK_HZ = 4;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_ena = 1'b0;
  logic       i_set_mode = 1'b0;
  logic       i_inc_hh = 1'b0;
  logic       i_inc_mm = 1'b0;
  logic       i_clr_ss = 1'b0;
  logic [7:0] o_hh;
  logic [7:0] o_mm;
  logic [7:0] o_ss;
  logic       o_pm;
  logic       o_clock_pulse;
  logic       o_input_pulse;
  logic       o_wr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: 24-hour clock plus prescaler and flags.
  int m_h24, m_m, m_s, m_presc;
  bit m_wr, m_cp, m_ip;

  clock_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_ena        (i_ena),
    .i_set_mode   (i_set_mode),
    .i_inc_hh     (i_inc_hh),
    .i_inc_mm     (i_inc_mm),
    .i_clr_ss     (i_clr_ss),
    .o_hh         (o_hh),
    .o_mm         (o_mm),
    .o_ss         (o_ss),
    .o_pm         (o_pm),
    .o_clock_pulse(o_clock_pulse),
    .o_input_pulse(o_input_pulse),
    .o_wr         (o_wr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       ena, sm, ih, im, cs;
    logic [7:0] hh, mm, ss;
    logic       pm, cp, ip, wr;
  } vec_t;

  vec_t tv[20];

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [26:0] model_vec();
    int h;
    h = m_h24 % 12;
    if (h == 0) h = 12;
    return {to_bcd(h), to_bcd(m_m), to_bcd(m_s), (m_h24 >= 12), m_cp, m_ip, m_wr};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {o_hh, o_mm, o_ss, o_pm, o_clock_pulse, o_input_pulse, o_wr};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_h24 = 0; m_m = 0; m_s = 0; m_presc = 0;
    m_wr = 0; m_cp = 0; m_ip = 0;
  endtask

  // One clock of the reference model, from the behavioural rules.
  task automatic model_step();
    int t;
    m_cp = 0;
    m_ip = 0;
    if (i_ena) begin
      if (!m_wr) begin
        if (m_presc == CLK_HZ - 1) begin
          m_presc = 0;
          m_cp = 1;
          t = (m_h24 * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h24 = t / 3600;
          m_m = (t / 60) % 60;
          m_s = t % 60;
        end else begin
          m_presc++;
        end
      end else begin
        m_presc = 0;
        if (i_inc_hh || i_inc_mm || i_clr_ss) begin
          if (i_inc_hh) m_h24 = (m_h24 + 1) % 24;
          if (i_inc_mm) m_m = (m_m + 1) % 60;
          if (i_clr_ss) m_s = 0;
          m_ip = 1;
        end
      end
      m_wr = i_set_mode;
    end
  endtask

  task automatic step(input string name);
    @(posedge i_clk);
    model_step();
    #1;
    chk(name, 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic reset_check(input string name);
    chk(name, 32'(dut_vec()), 32'({8'h12, 8'h00, 8'h00, 4'b0000}));
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_set_mode = 1'b0; i_inc_hh = 1'b0; i_inc_mm = 1'b0; i_clr_ss = 1'b0;
    i_ena = 1'b1;
    @(posedge i_clk);
    #1;
    reset_check("reset_hold");
    @(posedge i_clk);
    #3;
    i_reset = 1'b1;
    model_reset();
  endtask

  task automatic run_ticks(input int n);
    int seen = 0;
    int budget = n * CLK_HZ + 2 * CLK_HZ;
    i_ena = 1'b1;
    i_set_mode = 1'b0;
    while (seen < n && budget > 0) begin
      step("run");
      if (m_cp) seen++;
      budget--;
    end
    chk("run_ticks_done", 32'(seen), 32'(n));
  endtask

  // Edit to h24:mm via set mode, clear seconds, then run a number of ticks.
  task automatic goto_time(input int h24, input int mm, input int ticks);
    i_ena = 1'b1;
    i_set_mode = 1'b1;
    step("enter_set");
    for (int k = 0; k < 24 && m_h24 != h24; k++) begin
      i_inc_hh = 1'b1; step("edit_hh"); i_inc_hh = 1'b0;
    end
    for (int k = 0; k < 60 && m_m != mm; k++) begin
      i_inc_mm = 1'b1; step("edit_mm"); i_inc_mm = 1'b0;
    end
    i_clr_ss = 1'b1; step("edit_clr"); i_clr_ss = 1'b0;
    i_set_mode = 1'b0;
    step("leave_set");
    if (ticks > 0) run_ticks(ticks);
  endtask

  initial begin
    logic [7:0]  hh_snap;
    logic [26:0] snap;
    int          cnt_cp, cnt_ip, wait_cyc, exp_wait;

    // Vectors from reset: ena, set, inc_hh, inc_mm, clr_ss | hh, mm, ss, pm, clk_p, in_p, wr
    tv[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0};
    tv[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0};
    tv[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0};
    tv[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h01, 1'b0,1'b1,1'b0,1'b0};
    tv[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h01, 1'b0,1'b0,1'b0,1'b0};
    tv[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 8'h12,8'h00,8'h01, 1'b0,1'b0,1'b0,1'b0};
    tv[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h01, 1'b0,1'b0,1'b0,1'b0};
    tv[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h01, 1'b0,1'b0,1'b0,1'b0};
    tv[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h01, 1'b0,1'b0,1'b0,1'b0};
    tv[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h02, 1'b0,1'b1,1'b0,1'b0};
    tv[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 8'h12,8'h00,8'h02, 1'b0,1'b0,1'b0,1'b1};
    tv[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 8'h12,8'h01,8'h02, 1'b0,1'b0,1'b1,1'b1};
    tv[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 8'h01,8'h02,8'h00, 1'b0,1'b0,1'b1,1'b1};
    tv[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 8'h01,8'h02,8'h00, 1'b0,1'b0,1'b0,1'b1};
    tv[14] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 8'h01,8'h02,8'h00, 1'b0,1'b0,1'b0,1'b1};
    tv[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h01,8'h02,8'h00, 1'b0,1'b0,1'b0,1'b0};
    tv[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h01,8'h02,8'h00, 1'b0,1'b0,1'b0,1'b0};
    tv[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h01,8'h02,8'h00, 1'b0,1'b0,1'b0,1'b0};
    tv[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h01,8'h02,8'h00, 1'b0,1'b0,1'b0,1'b0};
    tv[19] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h01,8'h02,8'h01, 1'b0,1'b1,1'b0,1'b0};

    // Reset state, then the vector table.
    i_ena = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      i_ena = tv[i].ena; i_set_mode = tv[i].sm;
      i_inc_hh = tv[i].ih; i_inc_mm = tv[i].im; i_clr_ss = tv[i].cs;
      @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d", i), 32'(dut_vec()),
          32'({tv[i].hh, tv[i].mm, tv[i].ss, tv[i].pm, tv[i].cp, tv[i].ip, tv[i].wr}));
    end
    i_inc_hh = 1'b0; i_inc_mm = 1'b0; i_clr_ss = 1'b0;
    do_reset();

    // 11:59:59 AM -> 12:00:00 PM.
    goto_time(11, 59, 59);
    chk("pre_noon", 32'({o_hh, o_mm, o_ss, o_pm}), 32'({8'h11, 8'h59, 8'h59, 1'b0}));
    run_ticks(1);
    chk("noon", 32'({o_hh, o_mm, o_ss, o_pm, o_clock_pulse}), 32'({8'h12, 8'h00, 8'h00, 1'b1, 1'b1}));

    // 12:59:59 PM -> 01:00:00 PM, then 09:59:59 -> 10:00:00.
    goto_time(12, 59, 59);
    run_ticks(1);
    chk("one_pm", 32'({o_hh, o_mm, o_ss, o_pm}), 32'({8'h01, 8'h00, 8'h00, 1'b1}));
    goto_time(21, 59, 59);
    chk("pre_ten", 32'({o_hh, o_mm, o_ss}), 32'({8'h09, 8'h59, 8'h59}));
    run_ticks(1);
    chk("ten", 32'({o_hh, o_mm, o_ss, o_pm}), 32'({8'h10, 8'h00, 8'h00, 1'b1}));

    // Minute edit wrap 59->00 without hour carry, and no ticks in set mode.
    i_set_mode = 1'b1;
    step("enter_set2");
    for (int k = 0; k < 60 && m_m != 59; k++) begin
      i_inc_mm = 1'b1; step("edit_mm2"); i_inc_mm = 1'b0;
    end
    hh_snap = o_hh;
    i_inc_mm = 1'b1; step("mm_wrap"); i_inc_mm = 1'b0;
    chk("mm_wrap_val", 32'({o_hh, o_mm, o_input_pulse}), 32'({hh_snap, 8'h00, 1'b1}));
    cnt_cp = 0; cnt_ip = 0;
    for (int k = 0; k < 20; k++) begin
      step("set_idle");
      cnt_cp += int'(o_clock_pulse);
      cnt_ip += int'(o_input_pulse);
    end
    chk("set_no_clock_pulse", 32'(cnt_cp), 32'd0);
    chk("set_no_extra_input", 32'(cnt_ip), 32'd0);

    // Hour edit ignored outside set mode; disable freeze and resume.
    i_set_mode = 1'b0;
    step("leave_set2");
    step("run2");
    hh_snap = o_hh;
    i_inc_hh = 1'b1; step("ignored_hh"); i_inc_hh = 1'b0;
    chk("ignored_hh_val", 32'({o_hh, o_input_pulse}), 32'({hh_snap, 1'b0}));
    snap = dut_vec();
    i_ena = 1'b0;
    for (int k = 0; k < 10; k++) step("frozen");
    chk("frozen_outputs", 32'({o_hh, o_mm, o_ss, o_pm, o_wr}),
        32'({snap[26:3], snap[0]}));
    exp_wait = CLK_HZ - m_presc;
    i_ena = 1'b1;
    wait_cyc = 0;
    for (int k = 0; k < 2 * CLK_HZ && !o_clock_pulse; k++) begin
      step("resume");
      wait_cyc++;
    end
    chk("resume_latency", 32'(wait_cyc), 32'(exp_wait));

    // Asynchronous reset mid-count at 05:30:17 PM.
    goto_time(17, 30, 17);
    chk("pre_reset_time", 32'({o_hh, o_mm, o_ss, o_pm}), 32'({8'h05, 8'h30, 8'h17, 1'b1}));
    step("mid_presc");
    step("mid_presc");
    #2;
    i_reset = 1'b0;
    #1;
    reset_check("async_reset");
    do_reset();

    // Randomized traffic against the model.
    i_ena = 1'b1;
    i_set_mode = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      i_ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) i_set_mode = ~i_set_mode;
      i_inc_hh = ($urandom_range(0, 3) == 0);
      i_inc_mm = ($urandom_range(0, 3) == 0);
      i_clr_ss = ($urandom_range(0, 7) == 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
